rvfpm_xif_result_buffer: RTL and testbench
==========================================

Name: rvfpm_xif_result_buffer

Overview:
- Parametrised reorder/result buffer between the rvfpm execution pipeline and the CORE-V-XIF result interface.
- Records instruction ids in issue order and accepts completions from the FPU pipeline out of order.
- Presents results in issue order through a valid/ready handshake, with flush and error detection.
- Generalises the fixed PIPELINE_STAGES id tracking to a configurable-depth buffer with in-order retirement.

Parameters:
X_ID_WIDTH, 4, width of XIF instruction id
DEPTH, 4, number of in-flight entries; any value >= 1, not restricted to powers of two
FLEN, 32, result data width
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived, not overridden)

Ports:
ck  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries
issue_valid  in  1  new instruction offered
issue_ready  out  1  buffer accepts issue this cycle
issue_id  in  X_ID_WIDTH  id of issued instruction
issue_rd  in  5  destination register index
issue_to_xreg  in  1  1 = result targets integer regfile, 0 = FP regfile
cmpl_valid  in  1  pipeline completion strobe (always accepted)
cmpl_id  in  X_ID_WIDTH  id of completed instruction
cmpl_data  in  FLEN  result value
cmpl_fflags  in  5  exception flags
result_valid  out  1  head entry complete and presented
result_ready  in  1  consumer accepts result
result_id  out  X_ID_WIDTH  head id
result_data  out  FLEN  head data
result_rd  out  5  head destination
result_to_xreg  out  1  head regfile select
result_fflags  out  5  head flags
occupancy  out  CNT_W  entries in flight
err_cmpl  out  1  one-cycle pulse: completion did not match a pending entry

Behaviour:
- State: DEPTH entries {busy, done, id, rd, to_xreg, data, fflags}, head pointer, tail pointer, count. All are registers.
- Pointers wrap explicitly from DEPTH-1 to 0.
- Reset (rst=1 at rising edge): pointers 0, count 0, all busy/done 0, err_cmpl 0.
  - result_valid 0, issue_ready 1, occupancy 0.
  - result_* data outputs are don't-care while result_valid=0; the bench must not check them then.
- Reset asserted mid-operation discards every entry with no result emitted.
- issue_ready = (count < DEPTH) && !flush && !(any busy entry with id == issue_id).
  - Duplicate in-flight ids are refused, not overwritten.
  - issue_ready does not consider a same-cycle pop: when full, a pop and an issue never occur in the same cycle.
- Issue fire (issue_valid && issue_ready): write the tail entry with busy=1, done=0, id, rd, to_xreg; then tail++.
- Completion: when cmpl_valid=1, compare cmpl_id against all entries with busy=1 && done=0.
  - Exactly one match: store data and fflags, set done=1.
  - No match: no state change; err_cmpl=1 in the next cycle. This includes an id being issued in the same cycle, a done entry, or an unknown id.
- result_valid = busy[head] && done[head] && !flush. result_* reflect the head entry combinationally from registers.
- Latency: completion at edge N gives result_valid high after edge N, if that entry is at head. A younger done entry waits until all older entries pop.
- Pop (result_valid && result_ready): clear busy and done on head; then head++.
- count next = count + issue_fire - pop_fire. Simultaneous issue and pop leaves count unchanged.
- Simultaneous completion and pop of different entries are both performed.
- Flush (synchronous, highest priority after rst): no issue, completion, or pop takes effect that cycle.
  - Next cycle: all busy/done 0, pointers 0, count 0. err_cmpl is not raised for a completion dropped by flush.
- occupancy = count (registered).

Test Plan:
- Reset, then issue ids 3,5,7,9 (DEPTH=4) with result_ready=1 -> issue_ready=0 and occupancy=4 after the 4th issue. Complete id 9 then 7 then 5 then 3 with data 0x3F800000+id -> result_valid stays 0 until id 3 completes. Results then appear in order 3,5,7,9, one per cycle, with matching data.
- With id 2 in flight, offer issue_id=2 -> issue_ready=0, occupancy unchanged. Offer issue_id=4 -> accepted.
- Completion with cmpl_id=0xE when 0xE is not pending -> err_cmpl pulses high for exactly one cycle, occupancy and outputs unchanged. A second completion of an already-done id also pulses err_cmpl.
- DEPTH=3 build: run 10 issue/complete/pop rounds with result_ready toggling 1,0 -> pointers wrap at 2→0. Every id is returned exactly once, in order. With result_ready=1 and no issues pending, occupancy returns to 0 at the end of the run.
- Full buffer with head done and result_ready=1, issue_valid=1 in the same cycle -> pop occurs, issue is refused that cycle and accepted the next. occupancy goes 4→3→4.
- Flush asserted with 3 entries (one done) and cmpl_valid=1 -> next cycle occupancy=0, result_valid=0, err_cmpl=0. Issue id 1 is then accepted immediately.

Source files
------------

// File: rtl/rvfpm_xif_result_buffer_if.sv
// Issue / completion / result bundle between the rvfpm pipeline and the XIF result buffer.
// master = pipeline/consumer side, slave = the buffer itself.
interface rvfpm_xif_result_buffer_if #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned FLEN       = 32
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                  flush;
  logic                  issue_valid;
  logic                  issue_ready;
  logic [X_ID_WIDTH-1:0] issue_id;
  logic [4:0]            issue_rd;
  logic                  issue_to_xreg;
  logic                  cmpl_valid;
  logic [X_ID_WIDTH-1:0] cmpl_id;
  logic [FLEN-1:0]       cmpl_data;
  logic [4:0]            cmpl_fflags;
  logic                  result_valid;
  logic                  result_ready;
  logic [X_ID_WIDTH-1:0] result_id;
  logic [FLEN-1:0]       result_data;
  logic [4:0]            result_rd;
  logic                  result_to_xreg;
  logic [4:0]            result_fflags;
  logic [CNT_W-1:0]      occupancy;
  logic                  err_cmpl;

  modport master (
    output flush, issue_valid, issue_id, issue_rd, issue_to_xreg,
    output cmpl_valid, cmpl_id, cmpl_data, cmpl_fflags, result_ready,
    input  issue_ready, result_valid, result_id, result_data, result_rd,
    input  result_to_xreg, result_fflags, occupancy, err_cmpl
  );

  modport slave (
    input  flush, issue_valid, issue_id, issue_rd, issue_to_xreg,
    input  cmpl_valid, cmpl_id, cmpl_data, cmpl_fflags, result_ready,
    output issue_ready, result_valid, result_id, result_data, result_rd,
    output result_to_xreg, result_fflags, occupancy, err_cmpl
  );
endinterface

// File: rtl/rvfpm_xif_result_buffer.sv
// In-order result buffer: ids recorded at issue, completions accepted out of order,
// results retired from the head in issue order.
module rvfpm_xif_result_buffer #(
  parameter int unsigned X_ID_WIDTH = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned FLEN       = 32
) (
  input logic                      ck,
  input logic                      rst,
  rvfpm_xif_result_buffer_if.slave xif
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      done;
  logic [X_ID_WIDTH-1:0] ent_id     [DEPTH];
  logic [4:0]            ent_rd     [DEPTH];
  logic [FLEN-1:0]       ent_data   [DEPTH];
  logic [4:0]            ent_fflags [DEPTH];
  logic [DEPTH-1:0]      ent_to_xreg;
  logic [PTR_W-1:0]      head;
  logic [PTR_W-1:0]      tail;
  logic [CNT_W-1:0]      count;
  logic                  err_q;

  logic                  dup_c;
  logic                  issue_fire_c;
  logic                  pop_fire_c;
  logic                  cmpl_hit_c;
  logic [DEPTH-1:0]      match_c;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Duplicate-id detection for issue and id match for completion.
  always_comb begin
    dup_c   = 1'b0;
    match_c = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (busy[i] && (ent_id[i] == xif.issue_id)) dup_c = 1'b1;
      match_c[i] = xif.cmpl_valid && busy[i] && !done[i] && (ent_id[i] == xif.cmpl_id);
    end
  end

  assign cmpl_hit_c     = $onehot(match_c);
  assign xif.issue_ready  = (count < CNT_W'(DEPTH)) && !xif.flush && !dup_c;
  assign xif.result_valid = busy[head] && done[head] && !xif.flush;
  assign issue_fire_c   = xif.issue_valid && xif.issue_ready;
  assign pop_fire_c     = xif.result_valid && xif.result_ready;

  assign xif.result_id      = ent_id[head];
  assign xif.result_data    = ent_data[head];
  assign xif.result_rd      = ent_rd[head];
  assign xif.result_to_xreg = ent_to_xreg[head];
  assign xif.result_fflags  = ent_fflags[head];
  assign xif.occupancy      = count;
  assign xif.err_cmpl       = err_q;

  // Control state: flush and reset both empty the buffer.
  always_ff @(posedge ck) begin
    if (rst || xif.flush) begin
      busy  <= '0;
      done  <= '0;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= xif.cmpl_valid && !cmpl_hit_c;
      if (issue_fire_c) begin
        busy[tail] <= 1'b1;
        done[tail] <= 1'b0;
        tail       <= ptr_inc(tail);
      end
      if (cmpl_hit_c) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (match_c[i]) done[i] <= 1'b1;
        end
      end
      if (pop_fire_c) begin
        busy[head] <= 1'b0;
        done[head] <= 1'b0;
        head       <= ptr_inc(head);
      end
      count <= count + CNT_W'(issue_fire_c) - CNT_W'(pop_fire_c);
    end
  end

  // Payload storage; only meaningful while the entry is busy, so no reset.
  always_ff @(posedge ck) begin
    if (issue_fire_c) begin
      ent_id[tail]      <= xif.issue_id;
      ent_rd[tail]      <= xif.issue_rd;
      ent_to_xreg[tail] <= xif.issue_to_xreg;
    end
    if (cmpl_hit_c) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (match_c[i]) begin
          ent_data[i]   <= xif.cmpl_data;
          ent_fflags[i] <= xif.cmpl_fflags;
        end
      end
    end
  end
endmodule

// File: tb/tb_rvfpm_xif_result_buffer.sv
// Bench for rvfpm_xif_result_buffer: DEPTH=4 and DEPTH=3 instances share stimulus,
// one is selected at a time and compared against an issue-order queue model.
module tb_rvfpm_xif_result_buffer;
  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic [3:0]  issue_id = '0;
  logic [4:0]  issue_rd = '0;
  logic        issue_to_xreg = 1'b0;
  logic        cmpl_valid = 1'b0;
  logic [3:0]  cmpl_id = '0;
  logic [31:0] cmpl_data = '0;
  logic [4:0]  cmpl_fflags = '0;
  logic        result_ready = 1'b0;
  logic        sel = 1'b0;

  rvfpm_xif_result_buffer_if #(.X_ID_WIDTH(4), .DEPTH(4), .FLEN(32)) if4 ();
  rvfpm_xif_result_buffer_if #(.X_ID_WIDTH(4), .DEPTH(3), .FLEN(32)) if3 ();

  assign if4.flush = flush;           assign if3.flush = flush;
  assign if4.issue_valid = issue_valid;     assign if3.issue_valid = issue_valid;
  assign if4.issue_id = issue_id;           assign if3.issue_id = issue_id;
  assign if4.issue_rd = issue_rd;           assign if3.issue_rd = issue_rd;
  assign if4.issue_to_xreg = issue_to_xreg; assign if3.issue_to_xreg = issue_to_xreg;
  assign if4.cmpl_valid = cmpl_valid;       assign if3.cmpl_valid = cmpl_valid;
  assign if4.cmpl_id = cmpl_id;             assign if3.cmpl_id = cmpl_id;
  assign if4.cmpl_data = cmpl_data;         assign if3.cmpl_data = cmpl_data;
  assign if4.cmpl_fflags = cmpl_fflags;     assign if3.cmpl_fflags = cmpl_fflags;
  assign if4.result_ready = result_ready;   assign if3.result_ready = result_ready;

  rvfpm_xif_result_buffer #(.X_ID_WIDTH(4), .DEPTH(4), .FLEN(32)) u_dut4 (.ck(ck), .rst(rst), .xif(if4));
  rvfpm_xif_result_buffer #(.X_ID_WIDTH(4), .DEPTH(3), .FLEN(32)) u_dut3 (.ck(ck), .rst(rst), .xif(if3));

  logic        d_ir, d_rv, d_xreg, d_err;
  logic [3:0]  d_id;
  logic [31:0] d_data;
  logic [4:0]  d_rd, d_ff;
  logic [2:0]  d_occ;
  assign d_ir   = sel ? if3.issue_ready    : if4.issue_ready;
  assign d_rv   = sel ? if3.result_valid   : if4.result_valid;
  assign d_id   = sel ? if3.result_id      : if4.result_id;
  assign d_data = sel ? if3.result_data    : if4.result_data;
  assign d_rd   = sel ? if3.result_rd      : if4.result_rd;
  assign d_xreg = sel ? if3.result_to_xreg : if4.result_to_xreg;
  assign d_ff   = sel ? if3.result_fflags  : if4.result_fflags;
  assign d_occ  = sel ? {1'b0, if3.occupancy} : if4.occupancy;
  assign d_err  = sel ? if3.err_cmpl       : if4.err_cmpl;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: in-flight instructions in issue order.
  typedef struct {
    logic [3:0]  id;
    logic [4:0]  rd;
    logic        xreg;
    logic        done;
    logic [31:0] data;
    logic [4:0]  ff;
  } ment_t;

  ment_t      mq[$];
  logic       m_err = 1'b0;
  int         depth = 4;
  logic [3:0] popped[$];

  function automatic bit m_pending(input logic [3:0] id);
    foreach (mq[k]) if (mq[k].id == id) return 1'b1;
    return 1'b0;
  endfunction

  // Check outputs mid-cycle, then advance the model across the next rising edge.
  task automatic step();
    bit    e_ir, e_rv;
    int    hits, hit_k;
    ment_t e;
    #2;
    e_ir = (mq.size() < depth) && !flush && !m_pending(issue_id);
    e_rv = (mq.size() > 0) && mq[0].done && !flush;
    check("issue_ready", 64'(d_ir), 64'(e_ir));
    check("result_valid", 64'(d_rv), 64'(e_rv));
    check("occupancy", 64'(d_occ), 64'(mq.size()));
    check("err_cmpl", 64'(d_err), 64'(m_err));
    if (e_rv && d_rv) begin
      check("result_id", 64'(d_id), 64'(mq[0].id));
      check("result_data", 64'(d_data), 64'(mq[0].data));
      check("result_rd", 64'(d_rd), 64'(mq[0].rd));
      check("result_to_xreg", 64'(d_xreg), 64'(mq[0].xreg));
      check("result_fflags", 64'(d_ff), 64'(mq[0].ff));
    end
    if (d_rv && result_ready && !rst) popped.push_back(d_id);
    if (rst || flush) begin
      mq.delete();
      m_err = 1'b0;
    end else begin
      hits  = 0;
      hit_k = 0;
      if (cmpl_valid) begin
        foreach (mq[k]) if (!mq[k].done && mq[k].id == cmpl_id) begin hits++; hit_k = k; end
      end
      if (hits == 1) begin
        mq[hit_k].done = 1'b1;
        mq[hit_k].data = cmpl_data;
        mq[hit_k].ff   = cmpl_fflags;
      end
      m_err = cmpl_valid && (hits != 1);
      if (e_rv && result_ready) void'(mq.pop_front());
      if (e_ir && issue_valid) begin
        e.id = issue_id; e.rd = issue_rd; e.xreg = issue_to_xreg;
        e.done = 1'b0; e.data = '0; e.ff = '0;
        mq.push_back(e);
      end
    end
    @(posedge ck);
    #1;
  endtask

  task automatic do_issue(input logic [3:0] id);
    issue_valid = 1'b1; issue_id = id;
    issue_rd = 5'($urandom); issue_to_xreg = 1'($urandom);
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_cmpl(input logic [3:0] id, input logic [31:0] data);
    cmpl_valid = 1'b1; cmpl_id = id; cmpl_data = data; cmpl_fflags = 5'($urandom);
    step();
    cmpl_valid = 1'b0;
  endtask

  task automatic random_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      flush = ($urandom_range(0, 39) == 0);
      issue_valid = 1'($urandom); issue_id = 4'($urandom);
      issue_rd = 5'($urandom); issue_to_xreg = 1'($urandom);
      cmpl_valid = 1'($urandom);
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
        cmpl_id = mq[$urandom_range(0, mq.size() - 1)].id;
      else
        cmpl_id = 4'($urandom);
      cmpl_data = $urandom; cmpl_fflags = 5'($urandom);
      result_ready = 1'($urandom);
      step();
    end
    rst = 1'b0; flush = 1'b0; issue_valid = 1'b0; cmpl_valid = 1'b0;
  endtask

  logic [3:0] ids4[4];

  initial begin
    // Unchecked reset cycle to leave X state behind for both instances.
    @(posedge ck); @(posedge ck); #1;
    mq.delete(); m_err = 1'b0;
    step();
    rst = 1'b0;
    check("rst_occupancy", 64'(d_occ), 64'd0);
    check("rst_issue_ready", 64'(d_ir), 64'd1);
    check("rst_result_valid", 64'(d_rv), 64'd0);
    check("rst_err_cmpl", 64'(d_err), 64'd0);

    // Out-of-order completion, in-order retirement.
    ids4[0] = 4'd3; ids4[1] = 4'd5; ids4[2] = 4'd7; ids4[3] = 4'd9;
    result_ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 4; i++) do_issue(ids4[i]);
    issue_id = 4'd1; #1;
    check("full_occupancy", 64'(d_occ), 64'd4);
    check("full_issue_ready", 64'(d_ir), 64'd0);
    for (int i = 3; i >= 0; i--) begin
      do_cmpl(ids4[i], 32'h3F80_0000 + 32'(ids4[i]));
      if (i == 1) check("head_not_done", 64'(d_rv), 64'd0);
    end
    repeat (6) step();
    check("order_count", 64'(popped.size()), 64'd4);
    for (int i = 0; i < 4; i++) check("order_id", 64'(popped[i]), 64'(ids4[i]));

    // Duplicate in-flight id is refused.
    result_ready = 1'b0;
    do_issue(4'd2);
    issue_valid = 1'b1; issue_id = 4'd2; #1;
    check("dup_refused", 64'(d_ir), 64'd0);
    step();
    issue_valid = 1'b0;
    do_issue(4'd4);
    check("dup_then_accept_occ", 64'(d_occ), 64'd2);

    // Completion errors: unknown id, then an already-done id.
    do_cmpl(4'hE, $urandom);
    check("err_unknown_pulse", 64'(d_err), 64'd1);
    step();
    check("err_unknown_clear", 64'(d_err), 64'd0);
    do_cmpl(4'd2, $urandom);
    check("err_good_cmpl", 64'(d_err), 64'd0);
    do_cmpl(4'd2, $urandom);
    check("err_done_pulse", 64'(d_err), 64'd1);
    step();
    result_ready = 1'b1;
    do_cmpl(4'd4, $urandom);
    repeat (3) step();
    check("drain_occ", 64'(d_occ), 64'd0);

    // Full buffer: pop refuses same-cycle issue, accepted next cycle.
    result_ready = 1'b0;
    for (int i = 10; i < 14; i++) do_issue(4'(i));
    do_cmpl(4'd10, $urandom);
    check("fp_full_occ", 64'(d_occ), 64'd4);
    result_ready = 1'b1; issue_valid = 1'b1; issue_id = 4'd14; #1;
    check("fp_issue_refused", 64'(d_ir), 64'd0);
    step();
    check("fp_occ_after_pop", 64'(d_occ), 64'd3);
    step();
    check("fp_occ_refill", 64'(d_occ), 64'd4);
    issue_valid = 1'b0;
    for (int i = 11; i < 15; i++) do_cmpl(4'(i), $urandom);
    repeat (5) step();

    // Flush with a dropped completion.
    result_ready = 1'b0;
    do_issue(4'd1); do_issue(4'd2); do_issue(4'd3);
    do_cmpl(4'd2, $urandom);
    flush = 1'b1; cmpl_valid = 1'b1; cmpl_id = 4'd3;
    step();
    flush = 1'b0; cmpl_valid = 1'b0;
    check("flush_occ", 64'(d_occ), 64'd0);
    check("flush_result_valid", 64'(d_rv), 64'd0);
    check("flush_err", 64'(d_err), 64'd0);
    issue_valid = 1'b1; issue_id = 4'd1; #1;
    check("post_flush_ready", 64'(d_ir), 64'd1);
    step();
    issue_valid = 1'b0;
    check("post_flush_occ", 64'(d_occ), 64'd1);

    // Reset in the middle of traffic discards everything.
    do_issue(4'd6);
    do_cmpl(4'd1, $urandom);
    rst = 1'b1; step(); rst = 1'b0;
    check("midrst_occ", 64'(d_occ), 64'd0);
    check("midrst_valid", 64'(d_rv), 64'd0);

    random_run(500);

    // Switch to the DEPTH=3 instance.
    rst = 1'b1; @(posedge ck); #1;
    sel = 1'b1; depth = 3; mq.delete(); m_err = 1'b0;
    step();
    rst = 1'b0;
    popped.delete();
    for (int r = 0; r < 10; r++) begin
      result_ready = 1'b1;
      do_issue(4'(r));
      result_ready = 1'b0;
      do_cmpl(4'(r), $urandom);
    end
    result_ready = 1'b1;
    repeat (4) step();
    check("d3_count", 64'(popped.size()), 64'd10);
    for (int r = 0; r < 10; r++) check("d3_order", 64'(popped[r]), 64'(r));
    check("d3_final_occ", 64'(d_occ), 64'd0);

    random_run(500);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
